fpu_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one floating-point execution unit between up to 8 requesters.
- Chooses a winner, drives a one-hot grant (3-bit index decoded to 8 lines), pulses a start strobe to the FPU and holds the grant until the FPU signals done.
- Sits between the requester ports and the shared FPU datapath. Its grant lines steer the operand mux and route the result.

---
 rtl/fpu_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_fpu_rr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_rr_arbiter.sv
// fpu_rr_arbiter: round-robin arbiter/sequencer sharing one FPU among 8 requesters.
// Latency: req->gnt 1 cycle, start in first grant cycle, done->gnt drop 1 cycle.
// Backpressure: the grant is held until the FPU reports done; requests wait in IDLE.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req[7:0]           level-sensitive request vector
//   done               one-cycle FPU completion pulse
//   gnt[7:0]           registered one-hot grant, zero when no grant is held
//   gnt_idx[2:0]       index of current/last winner (qualify with gnt_valid)
//   gnt_valid, busy    grant held / ISSUE or BUSY
//   start              one-cycle FPU launch strobe
//   timeout_err        sticky watchdog flag
// Optional feature: define FPU_ARB_TIMEOUT_EN to build the BUSY watchdog
// (aborts after TIMEOUT_CYCLES BUSY cycles without done).
module fpu_rr_arbiter #(
    parameter int N_REQ          = 8,
    parameter int IDX_W          = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             start,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             grant_load;
    logic             release_op;
    logic             expire;

    // Rotating priority scan: first set bit at ptr, ptr+1, ... with 3-bit wrap.
    always_comb begin
        logic [IDX_W-1:0] idx;
        winner  = ptr;
        any_req = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_load = 1'b0;
        release_op = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_load = 1'b1;
                    state_d    = ISSUE;
                end
            end
            // done cannot legitimately arrive here, so it is not sampled.
            ISSUE: state_d = BUSY;
            BUSY: begin
                if (done || expire) begin
                    release_op = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            ptr       <= '0;
        end else begin
            state_q <= state_d;
            if (grant_load) begin
                gnt_idx   <= winner;
                gnt       <= N_REQ'(1) << winner;
                gnt_valid <= 1'b1;
            end else if (release_op) begin
                gnt       <= '0;
                gnt_valid <= 1'b0;
                ptr       <= gnt_idx + IDX_W'(1);
            end
        end
    end

    // Decoded from the state register only, so glitch-free and cleared by rst at once.
    assign start = (state_q == ISSUE);
    assign busy  = (state_q != IDLE);

`ifdef FPU_ARB_TIMEOUT_EN
    logic [15:0] busy_cnt;
    logic        tmo_flag;

    // busy_cnt counts completed BUSY cycles; expiry fires in the TIMEOUT_CYCLES-th one.
    assign expire = (state_q == BUSY) && (busy_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (state_q == ISSUE)
                busy_cnt <= '0;
            else if (state_q == BUSY)
                busy_cnt <= busy_cnt + 16'd1;
            // A simultaneous done counts as normal completion.
            if (expire && !done)
                tmo_flag <= 1'b1;
        end
    end

    assign timeout_err = tmo_flag;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
module tb_fpu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       start;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    fpu_rr_arbiter #(
        .N_REQ         (8),
        .IDX_W         (3),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid),
        .start      (start),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete operation from IDLE: grant, start, n_busy BUSY cycles, then done.
    task automatic do_op(input logic [7:0] req_v, input logic [2:0] exp_idx, input int n_busy);
        logic [7:0] exp_gnt;
        exp_gnt = 8'h01 << exp_idx;
        req = req_v;
        step();
        chk("issue_gnt", gnt, exp_gnt);
        chk("issue_idx", gnt_idx, exp_idx);
        chk("issue_start", start, 1'b1);
        chk("issue_valid", gnt_valid, 1'b1);
        step();
        chk("busy_start", start, 1'b0);
        chk("busy_gnt", gnt, exp_gnt);
        repeat (n_busy - 1) step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("rel_gnt", gnt, 8'h00);
        chk("rel_valid", gnt_valid, 1'b0);
        chk("rel_busy", busy, 1'b0);
    endtask

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        #12;
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_idx", gnt_idx, 3'd0);
        chk("rst_valid", gnt_valid, 1'b0);
        chk("rst_start", start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tmo", timeout_err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle_busy", busy, 1'b0);

        // All requesting from ptr=0: 0,1,...,7,0.
        for (int i = 0; i < 9; i++) do_op(8'hFF, 3'(i % 8), 2);

        // ptr=1 -> single request on 4, then ptr=5.
        do_op(8'h10, 3'd4, 3);
        chk("idx_retained", gnt_idx, 3'd4);

        // ptr=5: wrap past 7 to 0, then ptr=1 -> 4.
        do_op(8'h11, 3'd0, 2);
        do_op(8'h11, 3'd4, 2);

        // Grant on 2; changing req during BUSY has no effect until IDLE.
        req = 8'h04;
        step();
        chk("hold_issue_gnt", gnt, 8'h04);
        step();
        req = 8'h40;
        step();
        chk("hold_busy_gnt", gnt, 8'h04);
        step();
        chk("hold_busy_gnt2", gnt, 8'h04);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("hold_rel_gnt", gnt, 8'h00);
        step();
        chk("next_gnt6", gnt, 8'h40);
        step();
        chk("next_busy", busy, 1'b1);

        // Async reset mid-BUSY.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_start", start, 1'b0);
        chk("arst_valid", gnt_valid, 1'b0);
        req = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        req = 8'h01;
        step();
        chk("post_rst_gnt", gnt, 8'h01);
        // done during ISSUE is ignored.
        req  = 8'h00;
        done = 1'b1;
        step();
        done = 1'b0;
        chk("issue_done_gnt", gnt, 8'h01);
        chk("issue_done_busy", busy, 1'b1);
        step();
        chk("issue_done_gnt2", gnt, 8'h01);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("post_rst_rel", gnt, 8'h00);

        // done in IDLE is ignored.
        done = 1'b1;
        step();
        done = 1'b0;
        chk("idle_done_busy", busy, 1'b0);
        chk("idle_done_gnt", gnt, 8'h00);

`ifdef FPU_ARB_TIMEOUT_EN
        // No done: grant drops after 4 BUSY cycles and the flag sticks.
        req = 8'h02;
        step();
        chk("tmo_issue_gnt", gnt, 8'h02);
        req = 8'h00;
        repeat (4) step();
        chk("tmo_hold_gnt", gnt, 8'h02);
        chk("tmo_not_yet", timeout_err, 1'b0);
        step();
        chk("tmo_drop_gnt", gnt, 8'h00);
        chk("tmo_flag", timeout_err, 1'b1);
        do_op(8'h01, 3'd0, 2);
        chk("tmo_sticky", timeout_err, 1'b1);
`else
        chk("tmo_absent", timeout_err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Overall bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
